// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control sequencer: steps a shared ALU and unified memory through
// fetch/decode/execute/memory/writeback, handshaking with memory via mem_req/mem_ready.
module multicycle_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       iord,
   output logic       ir_write,
   output logic       pc_write,
   output logic [1:0] pcsrc,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] aluop,
   output logic       regwrite,
   output logic       regdst,
   output logic       memtoreg,
   output logic       instr_done,
   output logic       illegal_op,
   output logic [3:0] state
);

   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_ADD  = 6'b000000;
   localparam logic [5:0] OP_J    = 6'b000010;

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEM_RD  = 4'd3,
      MEM_WB  = 4'd4,
      MEM_WR  = 4'd5,
      EXEC_R  = 4'd6,
      ALU_WB  = 4'd7,
      EXEC_I  = 4'd8,
      ADDI_WB = 4'd9,
      BRANCH  = 4'd10,
      JUMP    = 4'd11
   } state_t;

   state_t     state_q, state_d;
   logic [5:0] op_q, op_d;

   // Next-state and output decode; reset forces every output low regardless of state
   always_comb begin
      state_d    = FETCH;
      op_d       = op_q;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pcsrc      = 2'b00;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      aluop      = 2'b00;
      regwrite   = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      instr_done = 1'b0;
      illegal_op = 1'b0;
      state      = 4'd0;
      if (!rst) begin
         state = state_q;
         case (state_q)
            FETCH: begin
               mem_req = 1'b1;
               alusrcb = 2'b01;
               if (mem_ready) begin
                  ir_write = 1'b1;
                  pc_write = 1'b1;
                  state_d  = DECODE;
               end else begin
                  state_d  = FETCH;
               end
            end
            DECODE: begin
               alusrcb = 2'b11;
               op_d    = opcode;
               case (opcode)
                  OP_LW, OP_SW:   state_d = MEMADR;
                  OP_ADD:         state_d = EXEC_R;
                  OP_ADDI:        state_d = EXEC_I;
                  OP_BEQ, OP_BNE: state_d = BRANCH;
                  OP_J:           state_d = JUMP;
                  default: begin
                     illegal_op = 1'b1;
                     instr_done = 1'b1;
                     state_d    = FETCH;
                  end
               endcase
            end
            MEMADR: begin
               alusrca = 1'b1;
               alusrcb = 2'b10;
               state_d = (op_q == OP_LW) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
               mem_req = 1'b1;
               iord    = 1'b1;
               state_d = mem_ready ? MEM_WB : MEM_RD;
            end
            MEM_WB: begin
               regwrite   = 1'b1;
               memtoreg   = 1'b1;
               instr_done = 1'b1;
               state_d    = FETCH;
            end
            MEM_WR: begin
               mem_req = 1'b1;
               mem_we  = 1'b1;
               iord    = 1'b1;
               if (mem_ready) begin
                  instr_done = 1'b1;
                  state_d    = FETCH;
               end else begin
                  state_d    = MEM_WR;
               end
            end
            EXEC_R: begin
               alusrca = 1'b1;
               aluop   = 2'b10;
               state_d = ALU_WB;
            end
            ALU_WB: begin
               regwrite   = 1'b1;
               regdst     = 1'b1;
               instr_done = 1'b1;
               state_d    = FETCH;
            end
            EXEC_I: begin
               alusrca = 1'b1;
               alusrcb = 2'b10;
               state_d = ADDI_WB;
            end
            ADDI_WB: begin
               regwrite   = 1'b1;
               instr_done = 1'b1;
               state_d    = FETCH;
            end
            BRANCH: begin
               alusrca    = 1'b1;
               aluop      = 2'b01;
               pcsrc      = 2'b01;
               instr_done = 1'b1;
               pc_write   = ((op_q == OP_BEQ) && zero) || ((op_q == OP_BNE) && !zero);
               state_d    = FETCH;
            end
            JUMP: begin
               pcsrc      = 2'b10;
               pc_write   = 1'b1;
               instr_done = 1'b1;
               state_d    = FETCH;
            end
            // unreachable encodings: outputs stay low and recover to FETCH
            default: begin
               state_d = FETCH;
            end
         endcase
      end
   end

   // State and latched opcode registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FETCH;
         op_q    <= 6'd0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
      end
   end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle sequencer for the MIPS datapath. It steps one shared ALU and one unified instruction/data memory through fetch, decode, execute, memory and writeback phases for LW, SW, ADDI, BEQ, BNE, ADD (R-type) and J. It sits between the instruction register/ALU-zero flag and the datapath muxes/enables, and handshakes with memory through a req/ready pair.

## Interface
- No parameters. Opcodes are fixed:
  - LW = 6'b100011, SW = 6'b101011, ADDI = 6'b001000
  - BEQ = 6'b000100, BNE = 6'b000101, ADD = 6'b000000, J = 6'b000010
- clk  in  1  sole clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  6  IR[31:26]; sampled only in DECODE.
- zero  in  1  ALU zero flag; used only in BRANCH.
- mem_ready  in  1  memory completes the current access this cycle (read data valid); ignored when mem_req=0.
- mem_req  out  1  memory access request; held high until mem_ready.
- mem_we  out  1  write qualifier for mem_req.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- ir_write  out  1  IR load enable.
- pc_write  out  1  PC load enable.
- pcsrc  out  2  PC source: 00 = ALU result, 01 = ALUOut (branch target), 10 = jump target.
- alusrca  out  1  ALU A select: 0 = PC, 1 = rs.
- alusrcb  out  2  ALU B select: 00 = rt, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- aluop  out  2  ALU operation: 00 = add, 01 = sub, 10 = funct decode.
- regwrite  out  1  register file write enable.
- regdst  out  1  destination register: 0 = rt, 1 = rd.
- memtoreg  out  1  writeback source: 0 = ALUOut, 1 = MDR.
- instr_done  out  1  one-cycle pulse in an instruction's final cycle.
- illegal_op  out  1  one-cycle pulse in DECODE when the opcode is unsupported.
- state  out  4  current state, for debug.

## Operation
- State register op_q (6 bits) captures opcode in DECODE and is used by every later state.
- Every output not listed for a state is 0.
- FETCH:
  - Drives mem_req=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00.
  - When mem_ready=1: ir_write=1, pc_write=1, go to DECODE. Otherwise stay.
- DECODE:
  - Drives alusrca=0, alusrcb=11, aluop=00 (branch target into ALUOut).
  - Next state: LW/SW → MEMADR; ADD → EXEC_R; ADDI → EXEC_I; BEQ/BNE → BRANCH; J → JUMP.
  - Any other opcode: illegal_op=1, instr_done=1, go to FETCH.
- MEMADR: alusrca=1, alusrcb=10, aluop=00. Go to MEM_RD if op_q=LW, else MEM_WR.
- MEM_RD: mem_req=1, iord=1. On mem_ready go to MEM_WB, else stay.
- MEM_WB: regwrite=1, regdst=0, memtoreg=1, instr_done=1. Go to FETCH.
- MEM_WR: mem_req=1, mem_we=1, iord=1. On mem_ready: instr_done=1, go to FETCH. Otherwise stay.
- EXEC_R: alusrca=1, alusrcb=00, aluop=10. Go to ALU_WB.
- ALU_WB: regwrite=1, regdst=1, memtoreg=0, instr_done=1. Go to FETCH.
- EXEC_I: alusrca=1, alusrcb=10, aluop=00. Go to ADDI_WB.
- ADDI_WB: regwrite=1, regdst=0, memtoreg=0, instr_done=1. Go to FETCH.
- BRANCH:
  - Drives alusrca=1, alusrcb=00, aluop=01, pcsrc=01, instr_done=1.
  - pc_write = (op_q=BEQ & zero) | (op_q=BNE & ~zero).
  - Go to FETCH.
- JUMP: pcsrc=10, pc_write=1, instr_done=1. Go to FETCH.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC_R=6, ALU_WB=7, EXEC_I=8, ADDI_WB=9, BRANCH=10, JUMP=11.
- States 12–15 are unreachable; if entered, all outputs are 0 and the next state is FETCH.

## Timing
- Reset:
  - While rst=1, every output is forced to 0 combinationally, including mem_req.
  - At the edge, state ← FETCH and op_q ← 0.
  - The first mem_req rises in the cycle after rst falls.
- Reset mid-access abandons the instruction. mem_req drops in the same cycle rst rises, and no enable pulses.
- Outputs are Moore-decoded from state, except these terms, which are combinational (Mealy):
  - FETCH ir_write/pc_write/next-state on mem_ready.
  - MEM_WR instr_done on mem_ready.
  - BRANCH pc_write on zero.
- Memory protocol:
  - Within one access, mem_req, iord and mem_we are stable until the mem_ready cycle.
  - mem_ready in the same cycle as mem_req is a zero-wait access.
- Latency with zero-wait memory, FETCH to final cycle inclusive:
  - LW 5 cycles.
  - SW, ADD, ADDI 4 cycles.
  - BEQ, BNE, J 3 cycles.
  - Illegal opcode 2 cycles.
  - Each wait cycle adds 1.
- FETCH always follows the instr_done cycle. There are no idle cycles between instructions.

## Test plan
- Reset held 3 cycles, then released with mem_ready=1 → all outputs 0 during reset; next cycle state=0, mem_req=1, ir_write=1, pc_write=1.
- LW, zero-wait → states 0,1,2,3,4. regwrite=1, memtoreg=1, regdst=0 only in the cycle with state=4. instr_done pulses once.
- SW with mem_ready low for 2 cycles in MEM_WR → mem_req=1, mem_we=1, iord=1 held 3 cycles; instr_done only on the ready cycle; total 6 cycles.
- Branch cases:
  - BEQ with zero=1 → pc_write=1, pcsrc=01 in state=10.
  - BEQ with zero=0 → pc_write=0.
  - BNE with zero=0 → pc_write=1.
- ADD then ADDI back-to-back → states 0,1,6,7,0,1,8,9. regdst=1 in state 7, regdst=0 in state 9.
- Robustness cases:
  - Opcode 6'b111111 → illegal_op=1 and instr_done=1 in DECODE, then FETCH.
  - rst asserted in MEM_RD → mem_req=0 the same cycle; state=0 the next cycle.
